// File: rtl/jk_mod_counter_pkg.sv
// Shared constants for the JK-cell modulo counter: default geometry and the
// {J,K} input encoding used to steer each storage cell.
package jk_mod_counter_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 10;

    // Encoding is {J,K}.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_code_e;

    // Pick the JK command that moves a cell from cur to nxt. Unchanged bits
    // get HOLD so a disabled counter drives J=K=0 on every cell.
    function automatic jk_code_e jk_encode(input logic cur, input logic nxt);
        if (cur == nxt) begin
            return JK_HOLD;
        end else if (nxt) begin
            return JK_SET;
        end else begin
            return JK_RESET;
        end
    endfunction

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// Single JK storage bit with asynchronous active-low clear.
module jk_cell
    import jk_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // Characteristic equation of a JK flip-flop.
    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    // Storage bit, cleared immediately when reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo counter built from JK cells, with saturating parallel load,
// combinational terminal count and a registered wrap pulse.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             tc_int;
    logic             wrap_q;
    logic             wrap_d;

    // Target count for the next edge: load (saturating) beats enabled step beats hold.
    // An out-of-range count left by a fault is pulled back to zero on any step.
    always_comb begin
        target = count_q;
        if (load) begin
            target = (int'(din) < MODULUS) ? din : MAX_VAL;
        end else if (en) begin
            if (int'(count_q) >= MODULUS) begin
                target = '0;
            end else if (up) begin
                target = (count_q == MAX_VAL) ? '0 : count_q + WIDTH'(1);
            end else begin
                target = (count_q == '0) ? MAX_VAL : count_q - WIDTH'(1);
            end
        end
    end

    // Terminal count: the step about to be taken wraps around.
    always_comb begin
        tc_int = en & ~load & ((up & (count_q == MAX_VAL)) | (~up & (count_q == '0)));
        wrap_d = tc_int;
    end

    // Translate the target count into per-cell J/K commands.
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_vec[i], k_vec[i]} = jk_encode(count_q[i], target[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (j_vec[gi]),
                .k     (k_vec[gi]),
                .q     (count_q[gi])
            );
        end
    endgenerate

    // Wrap pulse: one cycle high after each edge that took a wrapping step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q    = count_q;
    assign tc   = tc_int;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: a MODULUS=10 instance for the main
// behaviour and a MODULUS=16 instance for the full-range wrap check.
module tb_jk_mod_counter;

    logic       clk;
    // MODULUS=10 instance
    logic       r_reset, r_en, r_up, r_load;
    logic [3:0] r_din, r_q;
    logic       r_tc, r_wrap;
    // MODULUS=16 instance
    logic       s_reset, s_en, s_up, s_load;
    logic [3:0] s_din, s_q;
    logic       s_tc, s_wrap;

    int n_checks = 0;
    int n_pass   = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .reset(r_reset), .en(r_en), .up(r_up), .load(r_load),
        .din(r_din), .q(r_q), .tc(r_tc), .wrap(r_wrap)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .reset(s_reset), .en(s_en), .up(s_up), .load(s_load),
        .din(s_din), .q(s_q), .tc(s_tc), .wrap(s_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int w_count;
    int w_first;
    int w_second;

    initial begin
        r_reset = 1'b0; r_en = 1'b0; r_up = 1'b1; r_load = 1'b0; r_din = 4'd0;
        s_reset = 1'b0; s_en = 1'b0; s_up = 1'b1; s_load = 1'b0; s_din = 4'd0;

        // Reset held for two cycles
        step(); step();
        check("rst_q", r_q, 0);
        check("rst_wrap", r_wrap, 0);

        // Load/en ignored in reset; tc evaluates on q=0
        r_en = 1'b1; r_up = 1'b0; r_load = 1'b0;
        #1;
        check("rst_tc_down", r_tc, 1);
        r_load = 1'b1; r_din = 4'd5;
        step();
        check("rst_ignore_load_q", r_q, 0);
        check("rst_ignore_wrap", r_wrap, 0);
        r_en = 1'b0; r_load = 1'b0; r_up = 1'b1;

        // Release between edges, then count up 12 cycles
        r_reset = 1'b1;
        r_en = 1'b1; r_up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("up_q[%0d]", i), r_q, i % 10);
            check($sformatf("up_tc[%0d]", i), r_tc, ((i % 10) == 9) ? 1 : 0);
            check($sformatf("up_wrap[%0d]", i), r_wrap, (i == 10) ? 1 : 0);
        end

        // Load 7, then count down 9 cycles
        r_en = 1'b0; r_load = 1'b1; r_din = 4'd7;
        step();
        check("ld7_q", r_q, 7);
        check("ld7_wrap", r_wrap, 0);
        r_load = 1'b0; r_en = 1'b1; r_up = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("dn_q[%0d]", i), r_q, (17 - i) % 10);
            check($sformatf("dn_wrap[%0d]", i), r_wrap, (i == 8) ? 1 : 0);
        end

        // Saturating loads
        r_en = 1'b0; r_load = 1'b1; r_din = 4'd13;
        step();
        check("ld13_sat_q", r_q, 9);
        r_din = 4'd10;
        step();
        check("ld10_sat_q", r_q, 9);
        // Load beats a wrapping step at q=9
        r_en = 1'b1; r_up = 1'b1; r_din = 4'd3;
        #1;
        check("ld_over_en_tc", r_tc, 0);
        step();
        check("ld_over_en_q", r_q, 3);
        check("ld_over_en_wrap", r_wrap, 0);
        step();
        check("ld3_again_wrap", r_wrap, 0);

        // Hold at 4 with up toggling
        r_en = 1'b0; r_din = 4'd4;
        step();
        r_load = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            r_up = (i % 2 == 0);
            step();
            check($sformatf("hold_q[%0d]", i), r_q, 4);
            check($sformatf("hold_tc[%0d]", i), r_tc, 0);
            check($sformatf("hold_wrap[%0d]", i), r_wrap, 0);
        end

        // tc follows up immediately at q=9
        r_load = 1'b1; r_din = 4'd9;
        step();
        r_load = 1'b0; r_en = 1'b1; r_up = 1'b1;
        #1;
        check("tc_up_at9", r_tc, 1);
        r_up = 1'b0;
        #1;
        check("tc_down_at9", r_tc, 0);
        r_up = 1'b1;

        // Async reset pulse between edges at q=9 aborts the wrap
        #1;
        r_reset = 1'b0;
        #1;
        check("async_rst_q", r_q, 0);
        check("async_rst_wrap", r_wrap, 0);
        r_reset = 1'b1;
        step();
        check("post_rst_q", r_q, 1);
        check("post_rst_wrap", r_wrap, 0);
        r_en = 1'b0;

        // MODULUS=16: load top value without saturation, then free-run
        s_reset = 1'b1;
        s_load = 1'b1; s_din = 4'd15;
        step();
        check("m16_ld15_q", s_q, 15);
        s_load = 1'b0;
        s_reset = 1'b0;
        #1;
        check("m16_rst_q", s_q, 0);
        s_reset = 1'b1;
        s_en = 1'b1; s_up = 1'b1;
        w_count = 0; w_first = -1; w_second = -1;
        for (int i = 1; i <= 32; i++) begin
            step();
            check($sformatf("m16_q[%0d]", i), s_q, i % 16);
            if (s_wrap) begin
                w_count++;
                if (w_first < 0) w_first = i;
                else if (w_second < 0) w_second = i;
            end
        end
        check("m16_wrap_count", w_count, 2);
        check("m16_wrap_first", w_first, 16);
        check("m16_wrap_spacing", w_second - w_first, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
